stream_demux_2: RTL and testbench
=================================

// Module: stream_demux_2
// PURPOSE
//  Registered 1-to-2 demultiplexer for 32-bit pixel/word streams; the splitting counterpart of the 2:1 data mux.
//  Steers each packet from one valid/ready source to output port 0 or 1, chosen on the packet's first beat.
//  Sits between the memory/pixel fetch path and the two filter datapaths; one register stage per output.
// PARAMETERS
//  DATA_W  32  width of data on input and both outputs
//  CNT_W   16  width of per-port packet counters (DEMUX_CNT_EN only)
// PORTS
//  clk         in   1       single clock, rising edge
//  rst         in   1       asynchronous, active-high reset
//  in_data     in   DATA_W  input word
//  in_valid    in   1       input word valid
//  in_last     in   1       marks final beat of packet
//  in_sel      in   1       destination port; sampled only on first beat of a packet
//  in_ready    out  1       input accepted when in_valid & in_ready
//  out0_data   out  DATA_W  port 0 word
//  out0_valid  out  1       port 0 word valid
//  out0_last   out  1       port 0 last beat
//  out0_ready  in   1       port 0 sink ready
//  out1_data / out1_valid / out1_last / out1_ready   same as port 0, for port 1
//  busy        out  1       high while in BURST state
//  pkt_cnt0    out  CNT_W   packets delivered on port 0 (DEMUX_CNT_EN only)
//  pkt_cnt1    out  CNT_W   packets delivered on port 1 (DEMUX_CNT_EN only)
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, outN_valid=0, outN_data=0, outN_last=0, busy=0, counters=0.
//  Reset mid-packet discards buffered words and any partial packet; no output beat on the next cycle.
//  FSM, 2 states:
//    IDLE:  dest = in_sel (combinational). On accepted beat with in_last=0: latch dest, go BURST.
//           A single-beat packet (in_last=1) stays in IDLE.
//    BURST: dest = latched port; in_sel ignored. Accepted beat with in_last=1 -> IDLE.
//  Per-port output register: load on accepted beat to dest; clear valid when outN_valid & outN_ready and no load.
//  in_ready = ~out[dest]_valid | out[dest]_ready (comb); full throughput of 1 beat/cycle per port.
//  Simultaneous drain and load on the same port: the new word replaces the drained one, valid stays 1.
//  Latency: an accepted beat appears on outN one cycle later.
//  outN_data/outN_last hold stable while outN_valid & ~outN_ready; the non-dest port is never written.
//  Port stalling (out[dest]_ready=0 with register full) back-pressures input only; the other port keeps draining.
//  in_sel toggling while in_valid=0 or during BURST has no effect.
//  busy = (state == BURST).
// CONFIGURATION
//  DEMUX_CNT_EN defined:
//    pkt_cnt0/pkt_cnt1 increment by 1 when a beat with last=1 is handed off on that port (outN_valid & outN_ready & outN_last).
//    Counters wrap 2^CNT_W-1 -> 0.
//  DEMUX_CNT_EN undefined: counter logic and the pkt_cnt ports are removed.
// TESTING
//  Single beats: sel=0 data=0x0000_00AA last=1, then sel=1 data=0x0000_00BB last=1, both outputs ready ->
//    out0 shows 0xAA one cycle after acceptance, then out1 shows 0xBB; busy remains 0.
//  Sel lock: 4-beat packet 0x10..0x13 with sel=0 on beat 1 and sel=1 on beats 2-4 ->
//    all four words on out0 in order, out0_last only on 0x13; busy=1 from after beat 1 until after 0x13 is accepted.
//  Backpressure: out0_ready=0 with a 3-beat packet to port 0 -> in_ready=0 after the first beat;
//    out0_data holds the first word; releasing out0_ready drains the words one per cycle with no loss or duplication.
//  Independent port: out0 stalled and full, new packet with sel=1 ->
//    accepted and delivered on out1 while out0 holds its word.
//  Reset mid-packet: assert rst during beat 2 of a 4-beat packet to port 1 ->
//    all valid outputs are 0 immediately; after release, FSM is in IDLE and a new packet with sel=0 routes to out0.
//  With DEMUX_CNT_EN and CNT_W=2: 5 single-beat packets to port 1 -> pkt_cnt1 goes 1,2,3,0,1 and pkt_cnt0 stays 0.

Source files
------------

// File: rtl/stream_demux_2.sv
// Registered 1-to-2 valid/ready stream demultiplexer; destination chosen on a packet's first beat.
// Optional per-port packet counters are enabled with `define DEMUX_CNT_EN.
module stream_demux_2 #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  input  logic              in_sel,
  output logic              in_ready,
  output logic [DATA_W-1:0] out0_data,
  output logic              out0_valid,
  output logic              out0_last,
  input  logic              out0_ready,
  output logic [DATA_W-1:0] out1_data,
  output logic              out1_valid,
  output logic              out1_last,
  input  logic              out1_ready,
  output logic              busy
`ifdef DEMUX_CNT_EN
  ,
  output logic [CNT_W-1:0]  pkt_cnt0,
  output logic [CNT_W-1:0]  pkt_cnt1
`endif
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t state;
  logic   dest_q;
  logic   dest_c;
  logic   accept_c;
  logic   load0_c;
  logic   load1_c;

  // Destination follows in_sel only on a packet's first beat, then stays locked.
  assign dest_c   = (state == IDLE) ? in_sel : dest_q;
  assign in_ready = dest_c ? (~out1_valid | out1_ready) : (~out0_valid | out0_ready);
  assign accept_c = in_valid & in_ready;
  assign load0_c  = accept_c & ~dest_c;
  assign load1_c  = accept_c & dest_c;

  // Packet framing FSM; busy mirrors the BURST state as a register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      dest_q <= 1'b0;
      busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_c && !in_last) begin
            state  <= BURST;
            dest_q <= in_sel;
            busy   <= 1'b1;
          end
        end
        BURST: begin
          if (accept_c && in_last) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Port 0 output register: a load wins over a drain so valid stays high on back-to-back beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out0_data  <= '0;
      out0_last  <= 1'b0;
      out0_valid <= 1'b0;
    end else if (load0_c) begin
      out0_data  <= in_data;
      out0_last  <= in_last;
      out0_valid <= 1'b1;
    end else if (out0_valid && out0_ready) begin
      out0_valid <= 1'b0;
    end
  end

  // Port 1 output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out1_data  <= '0;
      out1_last  <= 1'b0;
      out1_valid <= 1'b0;
    end else if (load1_c) begin
      out1_data  <= in_data;
      out1_last  <= in_last;
      out1_valid <= 1'b1;
    end else if (out1_valid && out1_ready) begin
      out1_valid <= 1'b0;
    end
  end

`ifdef DEMUX_CNT_EN
  // Count packets as their last beat is handed to the sink; wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
    end else begin
      if (out0_valid && out0_ready && out0_last) pkt_cnt0 <= pkt_cnt0 + CNT_W'(1);
      if (out1_valid && out1_ready && out1_last) pkt_cnt1 <= pkt_cnt1 + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_stream_demux_2.sv
// Directed self-checking bench for stream_demux_2 (counter checks only when DEMUX_CNT_EN is defined).
module tb_stream_demux_2;

`ifdef DEMUX_CNT_EN
  localparam int unsigned TB_CNT_W = 2;
`else
  localparam int unsigned TB_CNT_W = 16;
`endif
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] in_data;
  logic              in_valid, in_last, in_sel, in_ready;
  logic [DATA_W-1:0] out0_data, out1_data;
  logic              out0_valid, out0_last, out0_ready;
  logic              out1_valid, out1_last, out1_ready;
  logic              busy;
`ifdef DEMUX_CNT_EN
  logic [TB_CNT_W-1:0] pkt_cnt0, pkt_cnt1;
`endif

  int tests = 0;
  int fails = 0;

  stream_demux_2 #(.DATA_W(DATA_W), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_sel(in_sel), .in_ready(in_ready),
    .out0_data(out0_data), .out0_valid(out0_valid), .out0_last(out0_last), .out0_ready(out0_ready),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_last(out1_last), .out1_ready(out1_ready),
    .busy(busy)
`ifdef DEMUX_CNT_EN
    , .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic sel, input logic [31:0] d, input logic last);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = d;
    in_last  = last;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_sel = 1'b0; in_data = '0;
    out0_ready = 1'b1; out1_ready = 1'b1;
    step(); step();
    chk("rst_out0_valid", 32'(out0_valid), 32'd0);
    chk("rst_out1_valid", 32'(out1_valid), 32'd0);
    chk("rst_out0_data", out0_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    step();

    // Single-beat packets to each port
    beat(1'b0, 32'hAA, 1'b1);
    #1 chk("single_in_ready", 32'(in_ready), 32'd1);
    step();
    chk("single0_valid", 32'(out0_valid), 32'd1);
    chk("single0_data", out0_data, 32'hAA);
    chk("single0_last", 32'(out0_last), 32'd1);
    chk("single0_out1_idle", 32'(out1_valid), 32'd0);
    chk("single0_busy", 32'(busy), 32'd0);
    beat(1'b1, 32'hBB, 1'b1);
    step();
    chk("single1_out0_drained", 32'(out0_valid), 32'd0);
    chk("single1_valid", 32'(out1_valid), 32'd1);
    chk("single1_data", out1_data, 32'hBB);
    chk("single1_busy", 32'(busy), 32'd0);
    in_valid = 1'b0;
    step();
    chk("single1_drained", 32'(out1_valid), 32'd0);

    // Sel lock: destination fixed by the first beat
    beat(1'b0, 32'h10, 1'b0);
    step();
    chk("lock_b0_data", out0_data, 32'h10);
    chk("lock_b0_last", 32'(out0_last), 32'd0);
    chk("lock_b0_busy", 32'(busy), 32'd1);
    for (int i = 1; i < 3; i++) begin
      beat(1'b1, 32'h10 + 32'(i), 1'b0);
      step();
      chk("lock_mid_data", out0_data, 32'h10 + 32'(i));
      chk("lock_mid_valid", 32'(out0_valid), 32'd1);
      chk("lock_mid_out1", 32'(out1_valid), 32'd0);
      chk("lock_mid_busy", 32'(busy), 32'd1);
    end
    beat(1'b1, 32'h13, 1'b1);
    step();
    chk("lock_end_data", out0_data, 32'h13);
    chk("lock_end_last", 32'(out0_last), 32'd1);
    chk("lock_end_out1", 32'(out1_valid), 32'd0);
    chk("lock_end_busy", 32'(busy), 32'd0);
    in_valid = 1'b0;
    step();

    // Backpressure on port 0
    out0_ready = 1'b0;
    beat(1'b0, 32'h20, 1'b0);
    step();
    chk("bp_first_data", out0_data, 32'h20);
    beat(1'b0, 32'h21, 1'b0);
    #1 chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    step();
    chk("bp_hold_data", out0_data, 32'h20);
    chk("bp_hold_valid", 32'(out0_valid), 32'd1);
    step();
    chk("bp_hold2_data", out0_data, 32'h20);
    out0_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(in_ready), 32'd1);
    step();
    chk("bp_second_data", out0_data, 32'h21);
    chk("bp_second_valid", 32'(out0_valid), 32'd1);
    beat(1'b0, 32'h22, 1'b1);
    step();
    chk("bp_third_data", out0_data, 32'h22);
    chk("bp_third_last", 32'(out0_last), 32'd1);
    in_valid = 1'b0;
    step();
    chk("bp_drained", 32'(out0_valid), 32'd0);
    chk("bp_busy", 32'(busy), 32'd0);

    // Port 1 proceeds while port 0 is stalled and full
    out0_ready = 1'b0;
    beat(1'b0, 32'h30, 1'b1);
    step();
    beat(1'b1, 32'h40, 1'b1);
    #1 chk("ind_in_ready", 32'(in_ready), 32'd1);
    step();
    chk("ind_out1_data", out1_data, 32'h40);
    chk("ind_out1_valid", 32'(out1_valid), 32'd1);
    chk("ind_out0_hold", out0_data, 32'h30);
    in_valid = 1'b0;
    step();
    chk("ind_out1_drained", 32'(out1_valid), 32'd0);
    chk("ind_out0_still", 32'(out0_valid), 32'd1);
    out0_ready = 1'b1;
    step();
    chk("ind_out0_drained", 32'(out0_valid), 32'd0);

    // Reset in the middle of a packet to port 1
    beat(1'b1, 32'h50, 1'b0);
    step();
    chk("rstmid_b0_data", out1_data, 32'h50);
    chk("rstmid_b0_busy", 32'(busy), 32'd1);
    beat(1'b1, 32'h51, 1'b0);
    rst = 1'b1;
    #1;
    chk("rstmid_out1_valid", 32'(out1_valid), 32'd0);
    chk("rstmid_out0_valid", 32'(out0_valid), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    in_valid = 1'b0;
    step();
    rst = 1'b0;
    step();
    chk("rstmid_no_beat", 32'(out1_valid), 32'd0);
    beat(1'b0, 32'h60, 1'b1);
    step();
    chk("rstmid_new_out0", 32'(out0_valid), 32'd1);
    chk("rstmid_new_data", out0_data, 32'h60);
    chk("rstmid_new_out1", 32'(out1_valid), 32'd0);
    chk("rstmid_new_busy", 32'(busy), 32'd0);
    in_valid = 1'b0;
    step();

`ifdef DEMUX_CNT_EN
    // Wrapping packet counter on port 1
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    for (int k = 1; k <= 5; k++) begin
      beat(1'b1, 32'h70 + 32'(k), 1'b1);
      step();
      in_valid = 1'b0;
      step();
      chk("cnt1_value", 32'(pkt_cnt1), 32'(k % 4));
      chk("cnt0_value", 32'(pkt_cnt0), 32'd0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
